// File: rtl/cpu_defs.sv
// Shared types for the MIPS pipeline: register addresses, data words,
// load operation encoding and the MEM-to-WB bus.
package cpu_defs;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] uint32_t;

   typedef enum logic [2:0] {
      NONE,
      LB,
      LBU,
      LH,
      LHU,
      LW,
      LWL,
      LWR
   } load_op_t;

   typedef struct packed {
      uint32_t   pc;
      logic      gpr_we;
      reg_addr_t dest;
      load_op_t  load_op;
      logic [1:0] addr_low;
      uint32_t   result;
   } ms_to_ws_bus_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: turns a retiring instruction's result into
// register-file byte-lane write enables and lane-aligned write data.
module load_align
   import cpu_defs::*;
(
   input  load_op_t   load_op,
   input  logic [1:0] addr_low,
   input  uint32_t    result,
   input  logic       gpr_we,
   input  reg_addr_t  dest,
   output logic [3:0] we,
   output uint32_t    wdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(result >> {addr_low, 3'b000});
      half_sel = 16'(result >> {addr_low[1], 4'b0000});
      we       = 4'b1111;
      wdata    = result;
      case (load_op)
         LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
         LBU: wdata = {24'h0, byte_sel};
         LH:  wdata = {{16{half_sel[15]}}, half_sel};
         LHU: wdata = {16'h0, half_sel};
         // Unaligned word loads merge into the old register value, so only
         // the lanes that receive memory bytes are written.
         LWL: begin
            wdata = result << {~addr_low, 3'b000};
            we    = 4'b1111 << ~addr_low;
         end
         LWR: begin
            wdata = result >> {addr_low, 3'b000};
            we    = 4'b1111 >> addr_low;
         end
         default: ;
      endcase
      if (!gpr_we || dest == 5'd0) begin
         we    = 4'b0000;
         wdata = '0;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: one-entry stage register, load alignment, MDU write
// arbitration, forwarding and retire counter. DEBUG_TRACE_EN adds trace ports.
module wb_stage
   import cpu_defs::*;
#(
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ms_to_ws_valid,
   input  ms_to_ws_bus_t           ms_to_ws_bus,
   output logic                    ws_allowin,
   input  logic                    ws_flush,
   input  logic                    mdu_req,
   input  logic [31:0]             mdu_pc,
   input  reg_addr_t               mdu_dest,
   input  uint32_t                 mdu_data,
   output logic                    mdu_ack,
   output logic [3:0]              rf_we,
   output reg_addr_t               rf_waddr,
   output uint32_t                 rf_wdata,
   output logic [3:0]              ws_fwd_we,
   output reg_addr_t               ws_fwd_dest,
   output uint32_t                 ws_fwd_data,
`ifdef DEBUG_TRACE_EN
   output logic [31:0]             debug_wb_pc,
   output logic [3:0]              debug_wb_rf_wen,
   output reg_addr_t               debug_wb_rf_wnum,
   output uint32_t                 debug_wb_rf_wdata,
`endif
   output logic [RETIRE_CNT_W-1:0] ws_retire_cnt
);

   logic                    ws_valid_q, ws_valid_d;
   ms_to_ws_bus_t           ws_bus_q, ws_bus_d;
   logic [RETIRE_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   logic       ws_ready_go;
   logic       pipe_write;
   logic [3:0] la_we;
   uint32_t    la_wdata;

   assign ws_ready_go = !mdu_req;
   assign ws_allowin  = !ws_valid_q || ws_ready_go;
   assign mdu_ack     = mdu_req;
   // A flushed instruction must not write even in the cycle the flush arrives.
   assign pipe_write  = ws_valid_q && !ws_flush;

   always_comb begin
      ws_valid_d   = ws_valid_q;
      ws_bus_d     = ws_bus_q;
      retire_cnt_d = retire_cnt_q;
      if (ms_to_ws_valid && ws_allowin) begin
         ws_valid_d = 1'b1;
         ws_bus_d   = ms_to_ws_bus;
      end else if (ws_flush || ws_ready_go) begin
         ws_valid_d = 1'b0;
      end
      if (ws_valid_q && ws_ready_go && !ws_flush) begin
         retire_cnt_d = retire_cnt_q + RETIRE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_q   <= 1'b0;
         ws_bus_q     <= '0;
         retire_cnt_q <= '0;
      end else begin
         ws_valid_q   <= ws_valid_d;
         ws_bus_q     <= ws_bus_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   load_align u_load_align (
      .load_op  (ws_bus_q.load_op),
      .addr_low (ws_bus_q.addr_low),
      .result   (ws_bus_q.result),
      .gpr_we   (ws_bus_q.gpr_we && pipe_write),
      .dest     (ws_bus_q.dest),
      .we       (la_we),
      .wdata    (la_wdata)
   );

   // MDU results are older than the held instruction, so they win the port.
   always_comb begin
      rf_we    = 4'b0000;
      rf_waddr = '0;
      rf_wdata = '0;
      if (mdu_req) begin
         if (mdu_dest != 5'd0) begin
            rf_we    = 4'b1111;
            rf_waddr = mdu_dest;
            rf_wdata = mdu_data;
         end
      end else if (la_we != 4'b0000) begin
         rf_we    = la_we;
         rf_waddr = ws_bus_q.dest;
         rf_wdata = la_wdata;
      end
   end

   assign ws_fwd_we     = rf_we;
   assign ws_fwd_dest   = rf_waddr;
   assign ws_fwd_data   = rf_wdata;
   assign ws_retire_cnt = retire_cnt_q;

`ifdef DEBUG_TRACE_EN
   always_comb begin
      debug_wb_pc       = mdu_req ? mdu_pc : ws_bus_q.pc;
      debug_wb_rf_wen   = rf_we;
      debug_wb_rf_wnum  = rf_waddr;
      debug_wb_rf_wdata = rf_wdata;
      if (reset) begin
         debug_wb_pc       = '0;
         debug_wb_rf_wen   = '0;
         debug_wb_rf_wnum  = '0;
         debug_wb_rf_wdata = '0;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second 3-bit-counter instance checks wrap.
module tb_wb_stage;
   import cpu_defs::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          ms_to_ws_valid;
   ms_to_ws_bus_t ms_to_ws_bus;
   logic          ws_flush;
   logic          mdu_req;
   logic [31:0]   mdu_pc;
   reg_addr_t     mdu_dest;
   uint32_t       mdu_data;

   logic        ws_allowin, mdu_ack;
   logic [3:0]  rf_we, ws_fwd_we;
   reg_addr_t   rf_waddr, ws_fwd_dest;
   uint32_t     rf_wdata, ws_fwd_data;
   logic [31:0] ws_retire_cnt;

   logic        s_allowin, s_mdu_ack;
   logic [3:0]  s_rf_we, s_fwd_we;
   reg_addr_t   s_rf_waddr, s_fwd_dest;
   uint32_t     s_rf_wdata, s_fwd_data;
   logic [2:0]  s_retire_cnt;

`ifdef DEBUG_TRACE_EN
   logic [31:0] debug_wb_pc, s_dbg_pc;
   logic [3:0]  debug_wb_rf_wen, s_dbg_wen;
   reg_addr_t   debug_wb_rf_wnum, s_dbg_wnum;
   uint32_t     debug_wb_rf_wdata, s_dbg_wdata;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   wb_stage #(.RETIRE_CNT_W(32)) dut (
      .clk               (clk),
      .reset             (reset),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allowin        (ws_allowin),
      .ws_flush          (ws_flush),
      .mdu_req           (mdu_req),
      .mdu_pc            (mdu_pc),
      .mdu_dest          (mdu_dest),
      .mdu_data          (mdu_data),
      .mdu_ack           (mdu_ack),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .ws_fwd_we         (ws_fwd_we),
      .ws_fwd_dest       (ws_fwd_dest),
      .ws_fwd_data       (ws_fwd_data),
`ifdef DEBUG_TRACE_EN
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
      .ws_retire_cnt     (ws_retire_cnt)
   );

   wb_stage #(.RETIRE_CNT_W(3)) dut_small (
      .clk               (clk),
      .reset             (reset),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allowin        (s_allowin),
      .ws_flush          (ws_flush),
      .mdu_req           (mdu_req),
      .mdu_pc            (mdu_pc),
      .mdu_dest          (mdu_dest),
      .mdu_data          (mdu_data),
      .mdu_ack           (s_mdu_ack),
      .rf_we             (s_rf_we),
      .rf_waddr          (s_rf_waddr),
      .rf_wdata          (s_rf_wdata),
      .ws_fwd_we         (s_fwd_we),
      .ws_fwd_dest       (s_fwd_dest),
      .ws_fwd_data       (s_fwd_data),
`ifdef DEBUG_TRACE_EN
      .debug_wb_pc       (s_dbg_pc),
      .debug_wb_rf_wen   (s_dbg_wen),
      .debug_wb_rf_wnum  (s_dbg_wnum),
      .debug_wb_rf_wdata (s_dbg_wdata),
`endif
      .ws_retire_cnt     (s_retire_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single edge, then drop valid.
   task automatic send(input logic [31:0] pc, input logic gpr_we, input reg_addr_t dest,
                       input load_op_t op, input logic [1:0] a, input uint32_t result);
      ms_to_ws_bus.pc       = pc;
      ms_to_ws_bus.gpr_we   = gpr_we;
      ms_to_ws_bus.dest     = dest;
      ms_to_ws_bus.load_op  = op;
      ms_to_ws_bus.addr_low = a;
      ms_to_ws_bus.result   = result;
      ms_to_ws_valid        = 1'b1;
      tick();
      ms_to_ws_valid = 1'b0;
      #1;
   endtask

   task automatic check_write(input string tag, input logic [3:0] we, input reg_addr_t addr,
                              input uint32_t data);
      check_eq({tag, "_we"}, {28'h0, rf_we}, {28'h0, we});
      check_eq({tag, "_waddr"}, {27'h0, rf_waddr}, {27'h0, addr});
      check_eq({tag, "_wdata"}, rf_wdata, data);
      check_eq({tag, "_fwd_dest"}, {27'h0, ws_fwd_dest}, {27'h0, addr});
   endtask

   task automatic check_cnt(input string tag);
      check_eq({tag, "_cnt"}, ws_retire_cnt, 32'(exp_cnt));
      check_eq({tag, "_cnt3"}, {29'h0, s_retire_cnt}, 32'(exp_cnt % 8));
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_allowin"}, {31'h0, ws_allowin}, 32'h1);
      check_eq({tag, "_ack"}, {31'h0, mdu_ack}, 32'h0);
      check_write(tag, 4'b0000, 5'd0, 32'h0);
      check_eq({tag, "_cnt"}, ws_retire_cnt, 32'h0);
   endtask

   initial begin
      reset          = 1'b1;
      ms_to_ws_valid = 1'b0;
      ms_to_ws_bus   = '0;
      ws_flush       = 1'b0;
      mdu_req        = 1'b0;
      mdu_pc         = '0;
      mdu_dest       = '0;
      mdu_data       = '0;
      tick();
      tick();
      check_reset_state("reset");
      reset = 1'b0;
      tick();

      send(32'h100, 1'b1, 5'd5, LWL, 2'd1, 32'h11223344);
      check_write("lwl", 4'b1100, 5'd5, 32'h33440000);
      check_eq("lwl_fwd_data", ws_fwd_data, 32'h33440000);
      tick(); exp_cnt++;
      check_cnt("lwl");

      send(32'h104, 1'b1, 5'd6, LWR, 2'd2, 32'hAABBCCDD);
      check_write("lwr", 4'b0011, 5'd6, 32'h0000AABB);
      tick(); exp_cnt++;

      send(32'h108, 1'b1, 5'd3, LB, 2'd3, 32'h80000000);
      check_write("lb", 4'b1111, 5'd3, 32'hFFFFFF80);
      tick(); exp_cnt++;
      check_cnt("lb");

      // LW to r7 held behind two MDU writes to r9.
      send(32'h10C, 1'b1, 5'd7, LW, 2'd0, 32'hCAFEF00D);
      mdu_req  = 1'b1;
      mdu_pc   = 32'h200;
      mdu_dest = 5'd9;
      mdu_data = 32'h1234;
      #1;
      check_eq("mdu1_allowin", {31'h0, ws_allowin}, 32'h0);
      check_eq("mdu1_ack", {31'h0, mdu_ack}, 32'h1);
      check_write("mdu1", 4'b1111, 5'd9, 32'h1234);
`ifdef DEBUG_TRACE_EN
      check_eq("mdu1_dbg_pc", debug_wb_pc, 32'h200);
`endif
      tick();
      check_eq("mdu2_allowin", {31'h0, ws_allowin}, 32'h0);
      check_write("mdu2", 4'b1111, 5'd9, 32'h1234);
      check_cnt("mdu2");
      tick();
      mdu_req = 1'b0;
      #1;
      check_eq("held_allowin", {31'h0, ws_allowin}, 32'h1);
      check_eq("held_ack", {31'h0, mdu_ack}, 32'h0);
      check_write("held_lw", 4'b1111, 5'd7, 32'hCAFEF00D);
      tick(); exp_cnt++;
      check_cnt("held_lw");
      check_eq("held_done_we", {28'h0, rf_we}, 32'h0);

      send(32'h110, 1'b1, 5'd0, LW, 2'd0, 32'h55555555);
      check_write("dest0", 4'b0000, 5'd0, 32'h0);
      tick(); exp_cnt++;
      check_cnt("dest0");

      send(32'h114, 1'b1, 5'd8, LW, 2'd0, 32'hDEADBEEF);
      ws_flush = 1'b1;
      #1;
      check_write("flush", 4'b0000, 5'd0, 32'h0);
      tick();
      ws_flush = 1'b0;
      #1;
      check_cnt("flush");
      check_eq("flush_after_we", {28'h0, rf_we}, 32'h0);

      send(32'h118, 1'b1, 5'd10, LHU, 2'd2, 32'h80010000);
      check_write("lhu", 4'b1111, 5'd10, 32'h00008001);
      tick(); exp_cnt++;

      send(32'h11C, 1'b1, 5'd11, LH, 2'd0, 32'h0000F00F);
      check_write("lh", 4'b1111, 5'd11, 32'hFFFFF00F);
      tick(); exp_cnt++;
      check_cnt("pre_wrap");

      send(32'h120, 1'b1, 5'd12, LBU, 2'd1, 32'h0000A500);
      check_write("lbu", 4'b1111, 5'd12, 32'h000000A5);
      tick(); exp_cnt++;
      check_cnt("wrap");

      // Reset arriving while an instruction is stalled behind the MDU.
      send(32'h124, 1'b1, 5'd13, LW, 2'd0, 32'h77777777);
      mdu_req = 1'b1;
      tick();
      mdu_req = 1'b0;
      reset   = 1'b1;
      tick();
      check_reset_state("rst_stall");
      reset = 1'b0;
      tick();
      check_reset_state("rst_drop");
      check_eq("rst_cnt3", {29'h0, s_retire_cnt}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
